// File: rtl/dvp_pixel_packer_pkg.sv
// dvp_pkg -- shared types and constants for the DVP byte-to-pixel packer.
//   dvp_state_e : packer state encoding (WAIT_SOF, ACTIVE, DROP)
//   ST_*        : plain logic aliases of the state codes for the FSM register
//   dvp_word_t  : FIFO word layout {user, last, data}
//   PIX_W / BYTE_W / WORD_W / STAT_W : pixel, byte, FIFO word and statistics widths
//   sat_inc     : saturating increment used by the optional statistics counters
package dvp_pkg;

  localparam int PIX_W  = 16;
  localparam int BYTE_W = 8;
  localparam int STAT_W = 12;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DROP     = 2'd2
  } dvp_state_e;

  localparam logic [1:0] ST_WAIT_SOF = WAIT_SOF;
  localparam logic [1:0] ST_ACTIVE   = ACTIVE;
  localparam logic [1:0] ST_DROP     = DROP;

  typedef struct packed {
    logic             user;
    logic             last;
    logic [PIX_W-1:0] data;
  } dvp_word_t;

  localparam int WORD_W = $bits(dvp_word_t);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dvp_pixel_packer_if.sv
// dvp_pixel_packer_if -- byte-in / pixel-out stream bundle for the packer.
//   s_tdata/s_tvalid/s_tlast/s_tuser : camera byte stream (no back-pressure)
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser : packed pixel stream
// Modports:
//   master : the environment side, drives the byte stream and m_tready
//   slave  : the packer side, consumes bytes and drives the pixel stream
interface dvp_pixel_packer_if;
  import dvp_pkg::*;

  logic [BYTE_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tuser;

  logic [PIX_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              m_tuser;

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tuser
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    output m_tdata, m_tvalid, m_tlast, m_tuser
  );

endinterface

// File: rtl/dvp_pixel_packer_fifo.sv
// dvp_sync_fifo -- single-clock first-word-fall-through FIFO.
//   clk, rst    : clock, synchronous active-high reset
//   wr_en_i     : write request (taken when not full, or full with a read)
//   wr_data_i   : write word
//   rd_en_i     : read request (pops the head when not empty)
//   rd_data_o   : head word, valid whenever empty_o is 0
//   full_o      : registered full flag
//   empty_o     : registered empty flag
// DEPTH must be a power of two so the pointers wrap naturally.
module dvp_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign do_rd = rd_en_i && !empty_q;
  assign do_wr = wr_en_i && (!full_q || do_rd);

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; the flags alone say what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/dvp_pixel_packer.sv
// dvp_pixel_packer -- packs a DVP camera byte stream into 16-bit pixels.
//   pclk, rst   : sole clock, synchronous active-high reset
//   bus         : dvp_pixel_packer_if.slave (byte stream in, pixel stream out)
//   clear_err   : clears both sticky flags (a same-cycle error wins)
//   overflow    : sticky, a pixel was dropped because the FIFO was full
//   odd_err     : sticky, odd line length or start-of-frame mid-pair
//   frame_lines : lines in the last completed frame   (DVP_PACK_STATS_EN only)
//   line_pixels : pixels in the last written line     (DVP_PACK_STATS_EN only)
// Optional feature macro: DVP_PACK_STATS_EN enables the frame statistics.
module dvp_pixel_packer
  import dvp_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                pclk,
  input  logic                rst,
  dvp_pixel_packer_if.slave   bus,
  input  logic                clear_err,
  output logic                overflow,
  output logic                odd_err
`ifdef DVP_PACK_STATS_EN
  ,
  output logic [STAT_W-1:0]   frame_lines,
  output logic [STAT_W-1:0]   line_pixels
`endif
);

  logic [1:0]        state_q, state_d;
  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] held_q, held_d;
  logic              held_user_q, held_user_d;
  logic              odd_q, ovf_q;
  logic              set_odd;
  logic              wr_req, wr_ok, fifo_rd;
  logic              fifo_full, fifo_empty, out_valid;
  dvp_word_t         wr_word, rd_word;

  // Mirror of the FIFO's own accept rule so a rejected pixel is seen here.
  assign fifo_rd = bus.m_tready && !fifo_empty;
  assign wr_ok   = !fifo_full || fifo_rd;

  // An SOF byte always opens a new pair whatever the state; in ACTIVE a
  // phase-0 byte does the same. A phase-0 byte carrying tlast is a short
  // line, so it is flushed at once with a zero partner byte.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    held_d      = held_q;
    held_user_d = held_user_q;
    wr_req      = 1'b0;
    wr_word     = '0;
    set_odd     = 1'b0;
    if (bus.s_tvalid) begin
      if (bus.s_tuser || (state_q == ST_ACTIVE && !phase_q)) begin
        if (state_q == ST_ACTIVE && phase_q) set_odd = 1'b1;
        state_d = ST_ACTIVE;
        if (bus.s_tlast) begin
          wr_req       = 1'b1;
          wr_word.data = MSB_FIRST ? {bus.s_tdata, 8'h00} : {8'h00, bus.s_tdata};
          wr_word.last = 1'b1;
          wr_word.user = bus.s_tuser;
          set_odd      = 1'b1;
          phase_d      = 1'b0;
        end else begin
          held_d      = bus.s_tdata;
          held_user_d = bus.s_tuser;
          phase_d     = 1'b1;
        end
      end else if (state_q == ST_ACTIVE) begin
        wr_req       = 1'b1;
        wr_word.data = MSB_FIRST ? {held_q, bus.s_tdata} : {bus.s_tdata, held_q};
        wr_word.last = bus.s_tlast;
        wr_word.user = held_user_q;
        phase_d      = 1'b0;
      end
    end
    // A dropped pixel abandons the frame until the next SOF.
    if (wr_req && !wr_ok) begin
      state_d = ST_DROP;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= ST_WAIT_SOF;
      phase_q     <= 1'b0;
      held_q      <= '0;
      held_user_q <= 1'b0;
      odd_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      held_q      <= held_d;
      held_user_q <= held_user_d;
      if (set_odd)               odd_q <= 1'b1;
      else if (clear_err)        odd_q <= 1'b0;
      if (wr_req && !wr_ok)      ovf_q <= 1'b1;
      else if (clear_err)        ovf_q <= 1'b0;
    end
  end

  dvp_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (pclk),
    .rst       (rst),
    .wr_en_i   (wr_req && wr_ok),
    .wr_data_i (wr_word),
    .rd_en_i   (bus.m_tready),
    .rd_data_o (rd_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Outputs are forced quiet during reset and zeroed whenever nothing is valid.
  assign out_valid    = !fifo_empty && !rst;
  assign bus.m_tvalid = out_valid;
  assign bus.m_tdata  = out_valid ? rd_word.data : '0;
  assign bus.m_tlast  = out_valid ? rd_word.last : 1'b0;
  assign bus.m_tuser  = out_valid ? rd_word.user : 1'b0;
  assign overflow     = ovf_q;
  assign odd_err      = odd_q;

`ifdef DVP_PACK_STATS_EN
  logic [STAT_W-1:0] pix_cnt_q, line_cnt_q, frame_lines_q, line_pixels_q;
  logic [STAT_W-1:0] pix_next, line_next;
  logic              wr_commit;

  assign wr_commit = wr_req && wr_ok;

  // An SOF pixel restarts both running counts before it is counted itself.
  always_comb begin
    pix_next  = sat_inc(wr_word.user ? '0 : pix_cnt_q);
    line_next = sat_inc(wr_word.user ? '0 : line_cnt_q);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
      line_pixels_q <= '0;
    end else if (wr_commit) begin
      if (wr_word.user) frame_lines_q <= line_cnt_q;
      if (wr_word.last) begin
        line_pixels_q <= pix_next;
        pix_cnt_q     <= '0;
        line_cnt_q    <= line_next;
      end else begin
        pix_cnt_q <= pix_next;
        if (wr_word.user) line_cnt_q <= '0;
      end
    end
  end

  assign frame_lines = frame_lines_q;
  assign line_pixels = line_pixels_q;
`endif

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// tb_dvp_pixel_packer -- directed self-checking bench for dvp_pixel_packer.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, so a pixel completed at a rising edge is checked half a cycle later.
// Observed pixel word is {m_tvalid, m_tuser, m_tlast, m_tdata}.
module tb_dvp_pixel_packer;
  import dvp_pkg::*;

  logic pclk;
  logic rst;
  logic clear_err;
  logic overflow;
  logic odd_err;
`ifdef DVP_PACK_STATS_EN
  logic [STAT_W-1:0] frame_lines;
  logic [STAT_W-1:0] line_pixels;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  dvp_pixel_packer_if bus();

  logic [18:0] obs;
  assign obs = {bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.m_tdata};

  dvp_pixel_packer #(
    .FIFO_DEPTH (16),
    .MSB_FIRST  (1'b1)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .bus       (bus.slave),
    .clear_err (clear_err),
    .overflow  (overflow),
    .odd_err   (odd_err)
`ifdef DVP_PACK_STATS_EN
    ,
    .frame_lines (frame_lines),
    .line_pixels (line_pixels)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Present one byte for one rising edge; returns at the following falling edge.
  task automatic applyStimulus(input logic [7:0] d, input logic user, input logic last);
    bus.s_tdata  = d;
    bus.s_tvalid = 1'b1;
    bus.s_tuser  = user;
    bus.s_tlast  = last;
    @(negedge pclk);
  endtask

  task automatic byteIdle();
    bus.s_tvalid = 1'b0;
    bus.s_tuser  = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = 8'h00;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 19'h0);
    end
    testsRun++;
    if ({overflow, odd_err} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 00", {overflow, odd_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.m_tready = 1'b1;
    applyStimulus(8'h12, 1'b1, 1'b0);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL basic_first_byte: got %h expected %h", obs, 19'h0);
    end
    applyStimulus(8'h34, 1'b0, 1'b0);
    testsRun++;
    if (obs !== {1'b1, 1'b1, 1'b0, 16'h1234}) begin
      testsFailed++;
      $display("[TB] FAIL basic_pix0: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 16'h1234});
    end
    applyStimulus(8'h56, 1'b0, 1'b0);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL basic_gap: got %h expected %h", obs, 19'h0);
    end
    applyStimulus(8'h78, 1'b0, 1'b1);
    testsRun++;
    if (obs !== {1'b1, 1'b0, 1'b1, 16'h5678}) begin
      testsFailed++;
      $display("[TB] FAIL basic_pix1: got %h expected %h", obs, {1'b1, 1'b0, 1'b1, 16'h5678});
    end
    byteIdle();
    @(negedge pclk);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL basic_drained: got %h expected %h", obs, 19'h0);
    end
  endtask

  task automatic test_no_sof();
    logic [7:0]  bytes [6] = '{8'h12, 8'h34, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic        users [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        lasts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [18:0] expect_obs [6] = '{19'h0, 19'h0, 19'h0, {3'b110, 16'hA1B2}, 19'h0, {3'b101, 16'hC3D4}};
    int          pixels = 0;
    pulseReset();
    bus.m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(bytes[i], users[i], lasts[i]);
      if (bus.m_tvalid) pixels++;
      testsRun++;
      if (obs !== expect_obs[i]) begin
        testsFailed++;
        $display("[TB] FAIL no_sof_byte%0d: got %h expected %h", i, obs, expect_obs[i]);
      end
    end
    byteIdle();
    repeat (3) begin
      @(negedge pclk);
      if (bus.m_tvalid) pixels++;
    end
    testsRun++;
    if (pixels != 2) begin
      testsFailed++;
      $display("[TB] FAIL no_sof_count: got %0d pixels expected 2", pixels);
    end
  endtask

  task automatic test_odd_line();
    applyStimulus(8'hAA, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    testsRun++;
    if (obs !== {3'b100, 16'hAABB}) begin
      testsFailed++;
      $display("[TB] FAIL odd_pix0: got %h expected %h", obs, {3'b100, 16'hAABB});
    end
    applyStimulus(8'hCC, 1'b0, 1'b1);
    testsRun++;
    if (obs !== {3'b101, 16'hCC00}) begin
      testsFailed++;
      $display("[TB] FAIL odd_pix1: got %h expected %h", obs, {3'b101, 16'hCC00});
    end
    byteIdle();
    repeat (3) @(negedge pclk);
    testsRun++;
    if (odd_err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL odd_sticky: got %b expected 1", odd_err);
    end
    clear_err = 1'b1;
    @(negedge pclk);
    clear_err = 1'b0;
    testsRun++;
    if (odd_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL odd_cleared: got %b expected 0", odd_err);
    end
  endtask

  task automatic test_sof_midpair();
    applyStimulus(8'h11, 1'b1, 1'b0);
    clear_err = 1'b1;
    applyStimulus(8'h33, 1'b1, 1'b0);
    clear_err = 1'b0;
    testsRun++;
    if (odd_err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midpair_set_wins: got %b expected 1", odd_err);
    end
    applyStimulus(8'h44, 1'b0, 1'b0);
    testsRun++;
    if (obs !== {3'b110, 16'h3344}) begin
      testsFailed++;
      $display("[TB] FAIL midpair_pix: got %h expected %h", obs, {3'b110, 16'h3344});
    end
    byteIdle();
    clear_err = 1'b1;
    @(negedge pclk);
    clear_err = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] expPix;
    bus.m_tready = 1'b0;
    for (int i = 0; i < 40; i++) applyStimulus(8'(i), (i == 0), 1'b0);
    byteIdle();
    testsRun++;
    if (overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ovf_flag: got %b expected 1", overflow);
    end
    repeat (3) @(negedge pclk);
    testsRun++;
    if (obs !== {3'b110, 16'h0001}) begin
      testsFailed++;
      $display("[TB] FAIL ovf_head_hold: got %h expected %h", obs, {3'b110, 16'h0001});
    end
    for (int k = 0; k < 16; k++) begin
      expPix = {8'(2 * k), 8'(2 * k + 1)};
      testsRun++;
      if (obs !== {1'b1, (k == 0), 1'b0, expPix}) begin
        testsFailed++;
        $display("[TB] FAIL ovf_drain%0d: got %h expected %h", k, obs, {1'b1, (k == 0), 1'b0, expPix});
      end
      bus.m_tready = 1'b1;
      @(negedge pclk);
    end
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL ovf_only16: got %h expected %h", obs, 19'h0);
    end
    applyStimulus(8'h77, 1'b0, 1'b0);
    applyStimulus(8'h88, 1'b0, 1'b0);
    byteIdle();
    @(negedge pclk);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL drop_discard: got %h expected %h", obs, 19'h0);
    end
    applyStimulus(8'hC1, 1'b1, 1'b0);
    applyStimulus(8'hC2, 1'b0, 1'b0);
    testsRun++;
    if (obs !== {3'b110, 16'hC1C2}) begin
      testsFailed++;
      $display("[TB] FAIL recover_pix0: got %h expected %h", obs, {3'b110, 16'hC1C2});
    end
    applyStimulus(8'hC3, 1'b0, 1'b0);
    applyStimulus(8'hC4, 1'b0, 1'b1);
    testsRun++;
    if (obs !== {3'b101, 16'hC3C4}) begin
      testsFailed++;
      $display("[TB] FAIL recover_pix1: got %h expected %h", obs, {3'b101, 16'hC3C4});
    end
    byteIdle();
    clear_err = 1'b1;
    @(negedge pclk);
    clear_err = 1'b0;
    testsRun++;
    if (overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ovf_cleared: got %b expected 0", overflow);
    end
  endtask

  task automatic test_reset_midpair();
    bus.m_tready = 1'b0;
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    byteIdle();
    testsRun++;
    if (obs !== {3'b110, 16'h0102}) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_before: got %h expected %h", obs, {3'b110, 16'h0102});
    end
    rst = 1'b1;
    @(negedge pclk);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_during: got %h expected %h", obs, 19'h0);
    end
    rst = 1'b0;
    @(negedge pclk);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_flushed: got %h expected %h", obs, 19'h0);
    end
    bus.m_tready = 1'b1;
    applyStimulus(8'h04, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    applyStimulus(8'h06, 1'b0, 1'b0);
    testsRun++;
    if (obs !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_no_sof: got %h expected %h", obs, 19'h0);
    end
    applyStimulus(8'h07, 1'b1, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b0);
    byteIdle();
    testsRun++;
    if (obs !== {3'b110, 16'h0708}) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_resume: got %h expected %h", obs, {3'b110, 16'h0708});
    end
    @(negedge pclk);
  endtask

`ifdef DVP_PACK_STATS_EN
  task automatic test_stats();
    pulseReset();
    bus.m_tready = 1'b1;
    for (int b = 0; b < 24; b++) applyStimulus(8'(b), (b == 0), (b % 8 == 7));
    testsRun++;
    if (line_pixels !== 12'd4) begin
      testsFailed++;
      $display("[TB] FAIL stats_line_pixels_f1: got %0d expected 4", line_pixels);
    end
    applyStimulus(8'hF0, 1'b1, 1'b0);
    applyStimulus(8'hF1, 1'b0, 1'b0);
    byteIdle();
    testsRun++;
    if ({frame_lines, line_pixels} !== {12'd3, 12'd4}) begin
      testsFailed++;
      $display("[TB] FAIL stats_after_sof: got lines %0d pixels %0d expected 3 4", frame_lines, line_pixels);
    end
    @(negedge pclk);
  endtask
`endif

  initial begin
    rst          = 1'b1;
    clear_err    = 1'b0;
    bus.m_tready = 1'b0;
    byteIdle();
    @(negedge pclk);
    test_reset();
    test_basic();
    test_no_sof();
    test_odd_line();
    test_sof_midpair();
    test_overflow();
    test_reset_midpair();
`ifdef DVP_PACK_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dvp_pixel_packer.md
DVP_PIXEL_PACKER -- requirements
Module: dvp_pixel_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, giving the output FIFO depth in pixel words (power of two, minimum 4).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; when 1, the first byte of a pair is pixel[15:8], otherwise pixel[7:0].
REQ-003 The block SHALL have these ports: pclk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-004 It SHALL have these slave ports, with no s_tready: s_tdata  in  8  byte; s_tvalid  in  1  byte valid; s_tlast  in  1  last byte of line; s_tuser  in  1  first byte of frame.
REQ-005 It SHALL have these master ports: m_tdata  out  16  pixel; m_tvalid  out  1; m_tready  in  1; m_tlast  out  1  last pixel of line; m_tuser  out  1  first pixel of frame.
REQ-006 It SHALL have these status ports: overflow  out  1  sticky FIFO-full drop; odd_err  out  1  sticky odd line length or mid-pair SOF; clear_err  in  1  clears both sticky flags.

Function
REQ-007 The state machine SHALL have the states WAIT_SOF, ACTIVE and DROP.
REQ-008 In WAIT_SOF, a byte with s_tuser=0 SHALL be discarded, and a byte with s_tuser=1 SHALL be taken as the first byte of a pair and move the state to ACTIVE.
REQ-009 In ACTIVE, a phase bit SHALL alternate per accepted byte, so that phase 0 holds the byte and phase 1 forms the pixel and writes {pixel, last, user} to the FIFO.
REQ-010 The pixel's user bit SHALL equal s_tuser of its phase-0 byte, and its last bit SHALL equal s_tlast of its phase-1 byte.
REQ-011 When s_tlast=1 arrives in phase 0, the block SHALL write the pixel with the missing byte as 0x00 and last=1, set odd_err, and return the phase to 0.
REQ-012 When s_tuser=1 arrives in phase 1, the block SHALL discard the held byte, set odd_err, and take the new byte as phase 0 of a new frame.
REQ-013 A pixel write SHALL be accepted when the FIFO is not full, or when it is full and a read occurs in the same cycle.
REQ-014 Otherwise the pixel SHALL be dropped, overflow set, and the state moved to DROP.
REQ-015 In DROP, bytes SHALL be discarded until a byte with s_tuser=1 arrives, which SHALL be handled as in REQ-008.
REQ-016 The FIFO SHALL be first-word fall-through with m_tvalid equal to not-empty; a pixel written in cycle N SHALL appear on m_tdata at cycle N+1.
REQ-017 m_tdata, m_tlast and m_tuser SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-018 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the occupancy count SHALL be one bit wider than the pointers.
REQ-019 If clear_err=1 coincides with a new error event, the set SHALL win.

Reset
REQ-020 On rst=1 at a pclk edge, the block SHALL enter WAIT_SOF with phase 0 and an empty FIFO, and clear overflow, odd_err and the statistics registers.
REQ-021 While rst=1, m_tvalid SHALL be 0; m_tdata, m_tlast and m_tuser SHALL be 0.
REQ-022 A reset asserted mid-frame SHALL discard the partial pixel and FIFO contents, and output SHALL resume only after the next SOF byte.

Configuration
REQ-023 The macro DVP_PACK_STATS_EN SHALL control frame statistics.
REQ-024 When DVP_PACK_STATS_EN is defined, the block SHALL have outputs frame_lines[11:0] and line_pixels[11:0].
REQ-025 frame_lines SHALL hold the count of lines in the last completed frame, latched at the next SOF pixel write.
REQ-026 line_pixels SHALL hold the pixel count of the last written line, latched at each last pixel; both counters SHALL saturate at 4095.
REQ-027 When DVP_PACK_STATS_EN is not defined, these ports and counters SHALL be absent.

Structure
REQ-028 Package dvp_pkg SHALL hold the state enum, the pixel-word width of 16, the FIFO word layout {user, last, data} of 18 bits, and the statistics width of 12.
REQ-029 The FIFO SHALL be the sub-module dvp_sync_fifo, parameterised by width and depth, with a registered full/empty/count.

Verification
REQ-030 Scenario: bytes 0x12,0x34(tuser on 0x12),0x56,0x78(tlast) with m_tready=1 -> pixels 0x1234 (user=1), then 0x5678 (last=1), each one cycle after its second byte.
REQ-031 Scenario: 0x12,0x34 bytes before any SOF -> no output; then an SOF line of 4 bytes -> exactly 2 pixels.
REQ-032 Scenario: a line of 3 bytes AA,BB,CC with tlast on CC -> pixels 0xAABB, 0xCC00 (last=1), and odd_err=1 until clear_err.
REQ-033 Scenario: m_tready=0 with FIFO_DEPTH=16 and 40 bytes -> 16 pixels held, overflow=1, state DROP; the next frame after m_tready=1 is delivered intact.
REQ-034 Scenario: rst pulsed between the bytes of a pair -> m_tvalid=0 the next cycle, and no pixel until a new SOF.
REQ-035 Scenario (STATS_EN): two frames of 3 lines x 4 pixels -> frame_lines=3 and line_pixels=4 after the second SOF.
